// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter feeding the single register-file write port.
// Optional combinational read bypass: define REGFILE_WRITE_ARBITER_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter bit DROP_XZR = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [4:0]               req0_addr,
    input  logic [63:0]              req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [4:0]               req1_addr,
    input  logic [63:0]              req1_data,
    output logic [4:0]               rf_DA,
    output logic [63:0]              rf_D,
    output logic                     rf_W,
    output logic                     grant_id,
    output logic [$clog2(DEPTH):0]   pend0,
    output logic [$clog2(DEPTH):0]   pend1
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    ,
    input  logic [4:0]               sa,
    input  logic [4:0]               sb,
    output logic                     a_fwd,
    output logic                     b_fwd,
    output logic [63:0]              fwd_a_data,
    output logic [63:0]              fwd_b_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef logic [68:0] entry_t;   // {addr, data}

    entry_t          mem [2][DEPTH];
    logic [AW-1:0]   wp [2];
    logic [AW-1:0]   rp [2];
    logic [AW:0]     cnt [2];
    entry_t          in_entry [2];
    logic [1:0]      in_valid;
    logic [1:0]      rdy;
    logic [1:0]      push;
    logic [1:0]      pop;
    logic [1:0]      ne;
    logic            grant;
    logic            winner;
    logic            last_grant;
    entry_t          head;

    assign in_valid    = {req1_valid, req0_valid};
    assign in_entry[0] = {req0_addr, req0_data};
    assign in_entry[1] = {req1_addr, req1_data};

    // Handshake: a transfer happens at a rising edge where valid && ready.
    // ready depends only on occupancy, so a same-cycle pop never raises it.
    // An XZR write is still handshaken when dropped, it just is not stored.
    always_comb begin
        rdy  = '0;
        push = '0;
        ne   = '0;
        for (int i = 0; i < 2; i++) begin
            rdy[i]  = (cnt[i] != FULL);
            push[i] = in_valid[i] && rdy[i] &&
                      !(DROP_XZR && (in_entry[i][68:64] == 5'd31));
            ne[i]   = (cnt[i] != '0);
        end
    end

    // Round robin: on a tie the requester that did not win last time goes.
    assign grant  = |ne;
    assign winner = (ne == 2'b11) ? ~last_grant : ne[1];
    assign pop    = {grant && winner, grant && !winner};
    assign head   = mem[winner][rp[winner]];

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign pend0      = cnt[0];
    assign pend1      = cnt[1];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) mem[i][wp[i]] <= in_entry[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]  <= '0;
                rp[i]  <= '0;
                cnt[i] <= '0;
            end
            rf_W       <= 1'b0;
            rf_DA      <= '0;
            rf_D       <= '0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            for (int i = 0; i < 2; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i])  rp[i] <= rp[i] + 1'b1;
                cnt[i] <= cnt[i] + {{AW{1'b0}}, push[i]} - {{AW{1'b0}}, pop[i]};
            end
            rf_W <= grant;
            if (grant) begin
                rf_DA      <= head[68:64];
                rf_D       <= head[63:0];
                grant_id   <= winner;
                last_grant <= winner;
            end
        end
    end

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    // The register file commits rf_D at the next edge; expose it to readers now.
    assign a_fwd      = rf_W && (rf_DA == sa) && (sa != 5'd31);
    assign b_fwd      = rf_W && (rf_DA == sb) && (sb != 5'd31);
    assign fwd_a_data = rf_D;
    assign fwd_b_data = rf_D;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: driver queues per requester,
// write scoreboard on the register-file port, register-file model.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [63:0] req0_data, req1_data;
    logic [4:0]  rf_DA;
    logic [63:0] rf_D;
    logic        rf_W;
    logic        grant_id;
    logic [1:0]  pend0, pend1;
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    logic [4:0]  sa, sb;
    logic        a_fwd, b_fwd;
    logic [63:0] fwd_a_data, fwd_b_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [68:0] src0_q[$];
    logic [68:0] src1_q[$];
    logic [69:0] exp_q[$];
    logic [63:0] rf_model [32];
    logic        fire0, fire1;

    regfile_write_arbiter #(.DEPTH(2), .DROP_XZR(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_DA      (rf_DA),
        .rf_D       (rf_D),
        .rf_W       (rf_W),
        .grant_id   (grant_id),
        .pend0      (pend0),
        .pend1      (pend1)
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
        ,
        .sa         (sa),
        .sb         (sb),
        .a_fwd      (a_fwd),
        .b_fwd      (b_fwd),
        .fwd_a_data (fwd_a_data),
        .fwd_b_data (fwd_b_data)
`endif
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] expected);
        checks++;
        if (obs !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expected, $time);
        end
    endtask

    // Driver tasks
    task automatic present();
        req0_valid = (src0_q.size() != 0);
        {req0_addr, req0_data} = (src0_q.size() != 0) ? src0_q[0] : 69'd0;
        req1_valid = (src1_q.size() != 0);
        {req1_addr, req1_data} = (src1_q.size() != 0) ? src1_q[0] : 69'd0;
    endtask

    task automatic cycle();
        @(negedge clock);
        fire0 = req0_valid && req0_ready;
        fire1 = req1_valid && req1_ready;
        @(posedge clock);
        #1;
        if (fire0) void'(src0_q.pop_front());
        if (fire1) void'(src1_q.pop_front());
        present();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        present();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Register-file model and write scoreboard
    always @(posedge clock) begin
        if (rf_W) rf_model[rf_DA] <= rf_D;
    end

    always begin
        @(posedge clock);
        #2;
        if (rf_W) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", rf_W, 1'b0);
            end else begin
                check("write", {grant_id, rf_DA, rf_D}, exp_q.pop_front());
            end
        end
    end

    initial begin
        fire0 = 1'b0;
        fire1 = 1'b0;
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
        sa = 5'd0;
        sb = 5'd0;
`endif
        apply_reset();

        // Reset then idle
        check("rst_rf_W", rf_W, 1'b0);
        check("rst_rf_DA", rf_DA, 5'd0);
        check("rst_rf_D", rf_D, 64'd0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_ready0", req0_ready, 1'b1);
        check("rst_ready1", req1_ready, 1'b1);
        check("rst_pend0", pend0, 2'd0);
        check("rst_pend1", pend1, 2'd0);

        // Single uncontended write: visible between t1 and t2
        src0_q.push_back({5'd5, 64'hDEAD_BEEF});
        exp_q.push_back({1'b0, 5'd5, 64'hDEAD_BEEF});
        present();
        cycle();
        check("single_t0_pend0", pend0, 2'd1);
        check("single_t0_rf_W", rf_W, 1'b0);
        cycle();
        check("single_t1_rf_W", rf_W, 1'b1);
        check("single_t1_rf_DA", rf_DA, 5'd5);
        check("single_t1_rf_D", rf_D, 64'hDEAD_BEEF);
        check("single_t1_grant", grant_id, 1'b0);
        check("single_t1_pend0", pend0, 2'd0);
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
        sa = 5'd5;
        sb = 5'd6;
        #1;
        check("byp_a_fwd", a_fwd, 1'b1);
        check("byp_a_data", fwd_a_data, 64'hDEAD_BEEF);
        check("byp_b_fwd", b_fwd, 1'b0);
`endif
        cycle();
        check("single_t2_rf_W", rf_W, 1'b0);
        check("single_t2_R05", rf_model[5], 64'hDEAD_BEEF);
        check("single_t2_rf_DA_hold", rf_DA, 5'd5);

        // XZR write is handshaken and discarded
        src0_q.push_back({5'd31, 64'h1234});
        present();
        cycle();
        check("xzr_handshake", fire0, 1'b1);
        check("xzr_pend0", pend0, 2'd0);
        check("xzr_ready0", req0_ready, 1'b1);
        cycle();
        check("xzr_no_write_a", rf_W, 1'b0);
        cycle();
        check("xzr_no_write_b", rf_W, 1'b0);

        // Continuous contention: grants alternate 0,1,0,1,0,1
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            src0_q.push_back({5'(1 + k), 64'h1000 + 64'(k)});
            src1_q.push_back({5'(10 + k), 64'h2000 + 64'(k)});
        end
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 5'(1 + k), 64'h1000 + 64'(k)});
            exp_q.push_back({1'b1, 5'(10 + k), 64'h2000 + 64'(k)});
        end
        present();
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_back_to_back", rf_W, 1'b1);
        end
        cycle();
        check("rr_idle_after", rf_W, 1'b0);
        check("rr_pend0_empty", pend0, 2'd0);
        check("rr_pend1_empty", pend1, 2'd0);

        // FIFO 1 fills behind req0 traffic, then reset with pend0=2, pend1=1
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            src0_q.push_back({5'(20 + k), 64'h3000 + 64'(k)});
            src1_q.push_back({5'd7, 64'h70 + 64'(k)});
        end
        exp_q.push_back({1'b0, 5'd20, 64'h3000});
        exp_q.push_back({1'b1, 5'd7, 64'h70});
        present();
        cycle();
        check("fill_e1_pend0", pend0, 2'd1);
        check("fill_e1_pend1", pend1, 2'd1);
        check("fill_e1_ready1", req1_ready, 1'b1);
        cycle();
        check("fill_e2_pend0", pend0, 2'd1);
        check("fill_e2_pend1", pend1, 2'd2);
        check("fill_e2_ready1", req1_ready, 1'b0);
        cycle();
        check("fill_e3_pend0", pend0, 2'd2);
        check("fill_e3_pend1", pend1, 2'd1);
        check("fill_e3_ready1", req1_ready, 1'b1);
        check("fill_e3_ready0", req0_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pend0", pend0, 2'd0);
        check("async_rst_pend1", pend1, 2'd0);
        check("async_rst_rf_W", rf_W, 1'b0);
        check("async_rst_rf_DA", rf_DA, 5'd0);
        check("async_rst_ready0", req0_ready, 1'b1);
        apply_reset();
        repeat (3) cycle();
        check("post_rst_idle", rf_W, 1'b0);

        check("scoreboard_drained", 70'(exp_q.size()), 70'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
